// File: rtl/imem_debug_arbiter.sv
// imem_debug_arbiter
//   Shares the single address/write port of the word-addressed instruction
//   memory between the core fetch path and the external debug module. Debug
//   reads and writes are serialised through a req/ack handshake. The core is
//   stalled only for the one cycle in which the debugger owns the memory.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         synchronous, active-high reset
//   core_pc_i     core fetch byte address
//   core_instr_o  instruction to the core (combinational from memory)
//   core_stall_o  core must hold its pc and ignore core_instr_o
//   dbg_req_i     debug request, held until dbg_ack_o
//   dbg_we_i      1 = write, 0 = read (sampled with dbg_req_i)
//   dbg_addr_i    debug byte address (sampled with dbg_req_i)
//   dbg_wdata_i   debug write data (sampled with dbg_req_i)
//   dbg_ack_o     one-cycle completion pulse
//   dbg_rdata_o   read data (write data echo on writes), held until next ack
//   dbg_err_o     valid with dbg_ack_o: misaligned or out-of-range request
//   mem_addr_o    word address to memory
//   mem_we_o      memory write strobe, commits on the closing rising edge
//   mem_wdata_o   memory write data
//   mem_rdata_i   asynchronous memory read data for mem_addr_o
module imem_debug_arbiter #(
    parameter int unsigned DEPTH = 1000,
    parameter int unsigned AW    = 30
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [31:0]   core_pc_i,
    output logic [31:0]   core_instr_o,
    output logic          core_stall_o,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [31:0]   dbg_addr_i,
    input  logic [31:0]   dbg_wdata_i,
    output logic          dbg_ack_o,
    output logic [31:0]   dbg_rdata_o,
    output logic          dbg_err_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StAck,
        StRelease
    } state_e;

    state_e        state_q;

    // Captured debug transaction
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    // Registered outputs
    logic          stall_q;
    logic          mem_we_q;
    logic          ack_q;
    logic          dbg_err_q;
    logic [31:0]   rdata_q;

    logic          req_err;
    logic          core_oor;
    logic [AW-1:0] core_word;
    logic          unused_pc;

    assign req_err   = (dbg_addr_i[1:0] != 2'b00) || ({2'b00, dbg_addr_i[31:2]} >= DEPTH);
    assign core_oor  = {2'b00, core_pc_i[31:2]} >= DEPTH;
    assign core_word = core_pc_i[AW+1:2];
    assign unused_pc = ^core_pc_i[1:0];

    // stall_q and mem_we_q are set on the IDLE->ACCESS edge so they are high
    // exactly during the ACCESS cycle of a non-error transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            stall_q   <= 1'b0;
            mem_we_q  <= 1'b0;
            ack_q     <= 1'b0;
            dbg_err_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            stall_q   <= 1'b0;
            mem_we_q  <= 1'b0;
            ack_q     <= 1'b0;
            dbg_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (dbg_req_i) begin
                        we_q     <= dbg_we_i;
                        addr_q   <= dbg_addr_i[AW+1:2];
                        wdata_q  <= dbg_wdata_i;
                        err_q    <= req_err;
                        stall_q  <= ~req_err;
                        mem_we_q <= dbg_we_i & ~req_err;
                        state_q  <= StAccess;
                    end
                end
                StAccess: begin
                    if (err_q) begin
                        rdata_q <= 32'h0;
                    end else if (we_q) begin
                        rdata_q <= wdata_q;
                    end else begin
                        rdata_q <= mem_rdata_i;
                    end
                    ack_q     <= 1'b1;
                    dbg_err_q <= err_q;
                    state_q   <= StAck;
                end
                StAck: begin
                    state_q <= StRelease;
                end
                StRelease: begin
                    // Wait for the request to drop so the core always gets
                    // at least two owned cycles between debug accesses.
                    if (!dbg_req_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr_o   = '0;
        core_instr_o = 32'h0;
        if (stall_q) begin
            mem_addr_o = addr_q;
        end else if (!core_oor) begin
            mem_addr_o   = core_word;
            core_instr_o = mem_rdata_i;
        end
    end

    // Gate with reset so a write caught by reset in ACCESS never commits.
    assign mem_we_o     = mem_we_q & ~rst_i;
    assign mem_wdata_o  = wdata_q;
    assign core_stall_o = stall_q;
    assign dbg_ack_o    = ack_q;
    assign dbg_err_o    = dbg_err_q;
    assign dbg_rdata_o  = rdata_q;

endmodule

// File: tb/tb_imem_debug_arbiter.sv
// Directed bench for imem_debug_arbiter with a behavioural async-read memory.
module tb_imem_debug_arbiter;

    localparam int unsigned DEPTH = 1000;
    localparam int unsigned AW    = 30;

    logic          clk;
    logic          rst;
    logic [31:0]   core_pc;
    logic [31:0]   core_instr;
    logic          core_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [31:0]   dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_ack;
    logic [31:0]   dbg_rdata;
    logic          dbg_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem [DEPTH];
    logic          mem_load;
    int            we_cnt;
    int            stall_cnt;
    int            n_tests;
    int            n_fail;

    imem_debug_arbiter #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .core_pc_i   (core_pc),
        .core_instr_o(core_instr),
        .core_stall_o(core_stall),
        .dbg_req_i   (dbg_req),
        .dbg_we_i    (dbg_we),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
        .dbg_ack_o   (dbg_ack),
        .dbg_rdata_o (dbg_rdata),
        .dbg_err_o   (dbg_err),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i preloads to 0xA000_0000 + i, word 10 = 0x0034A503.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= (i == 10) ? 32'h0034_A503 : 32'hA000_0000 + i;
            end
        end else if (mem_we && (int'(mem_addr) < int'(DEPTH))) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = 32'h0;
        if (int'(mem_addr) < int'(DEPTH)) begin
            mem_rdata = mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (core_stall) stall_cnt <= stall_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One full transaction starting from IDLE at a falling edge; returns in IDLE.
    task automatic dbg_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_rdata, input logic [31:0] fetch_pc,
                           input logic [31:0] exp_fetch);
        int we0;
        int st0;
        we0       = we_cnt;
        st0       = stall_cnt;
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
        @(negedge clk);  // ACCESS
        chk({tag, "_acc_stall"}, 32'(core_stall), 32'(!exp_err));
        chk({tag, "_acc_we"}, 32'(mem_we), 32'(we && !exp_err));
        chk({tag, "_acc_ack"}, 32'(dbg_ack), 32'h0);
        if (!exp_err) chk({tag, "_acc_addr"}, 32'(mem_addr), {2'b00, addr[31:2]});
        @(negedge clk);  // ACK
        chk({tag, "_ack"}, 32'(dbg_ack), 32'h1);
        chk({tag, "_err"}, 32'(dbg_err), 32'(exp_err));
        chk({tag, "_rdata"}, dbg_rdata, exp_rdata);
        chk({tag, "_ack_stall"}, 32'(core_stall), 32'h0);
        core_pc = fetch_pc;
        #1;
        chk({tag, "_fetch"}, core_instr, exp_fetch);
        dbg_req = 1'b0;
        @(negedge clk);  // RELEASE
        chk({tag, "_ack_pulse"}, 32'(dbg_ack), 32'h0);
        chk({tag, "_rdata_hold"}, dbg_rdata, exp_rdata);
        @(negedge clk);  // IDLE
        chk({tag, "_we_cycles"}, 32'(we_cnt - we0), 32'(we && !exp_err));
        chk({tag, "_stall_cycles"}, 32'(stall_cnt - st0), 32'(!exp_err));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        we_cnt    = 0;
        stall_cnt = 0;
        rst       = 1'b1;
        mem_load  = 1'b1;
        core_pc   = 32'h0;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = 32'h0;
        dbg_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        mem_load = 1'b0;

        // Reset state
        chk("rst_stall", 32'(core_stall), 32'h0);
        chk("rst_ack", 32'(dbg_ack), 32'h0);
        chk("rst_err", 32'(dbg_err), 32'h0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Core fetch tracks memory combinationally
        core_pc = 32'h08; #1;
        chk("fetch_w2", core_instr, 32'hA000_0002);
        chk("fetch_w2_stall", 32'(core_stall), 32'h0);
        @(negedge clk);
        core_pc = 32'h0C; #1;
        chk("fetch_w3", core_instr, 32'hA000_0003);
        @(negedge clk);
        core_pc = 32'h10; #1;
        chk("fetch_w4", core_instr, 32'hA000_0004);
        chk("fetch_w4_stall", 32'(core_stall), 32'h0);
        @(negedge clk);
        core_pc = 32'h0000_0FA0; #1;
        chk("fetch_oor_instr", core_instr, 32'h0);
        chk("fetch_oor_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);

        // Debug write, then read, then two error writes
        dbg_txn("wr24", 1'b1, 32'h24, 32'h0010_0073, 1'b0, 32'h0010_0073,
                32'h24, 32'h0010_0073);
        chk("wr24_mem", mem[9], 32'h0010_0073);
        dbg_txn("rd28", 1'b0, 32'h28, 32'hFFFF_FFFF, 1'b0, 32'h0034_A503,
                32'h28, 32'h0034_A503);
        chk("rd28_mem", mem[10], 32'h0034_A503);
        dbg_txn("wr26", 1'b1, 32'h26, 32'h1234_5678, 1'b1, 32'h0,
                32'h26, 32'h0010_0073);
        dbg_txn("wrFA0", 1'b1, 32'hFA0, 32'h8765_4321, 1'b1, 32'h0,
                32'hFA0, 32'h0);
        chk("err_mem9", mem[9], 32'h0010_0073);
        chk("err_mem999", mem[999], 32'hA000_03E7);

        // Request held after ack: no second transaction
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 32'h08;
        @(negedge clk);
        @(negedge clk);
        chk("hold_ack", 32'(dbg_ack), 32'h1);
        chk("hold_rdata", dbg_rdata, 32'hA000_0002);
        core_pc = 32'h10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("hold_no_ack", 32'(dbg_ack), 32'h0);
            chk("hold_no_stall", 32'(core_stall), 32'h0);
            chk("hold_core_instr", core_instr, 32'hA000_0004);
        end
        dbg_req = 1'b0;
        @(negedge clk);
        dbg_txn("rd0C", 1'b0, 32'h0C, 32'h0, 1'b0, 32'hA000_0003, 32'h10, 32'hA000_0004);

        // Reset during the ACCESS cycle of a write
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 32'h24;
        dbg_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rstacc_stall", 32'(core_stall), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstacc_we_gated", 32'(mem_we), 32'h0);
        @(negedge clk);
        chk("rstacc_ack", 32'(dbg_ack), 32'h0);
        chk("rstacc_stall_clr", 32'(core_stall), 32'h0);
        chk("rstacc_rdata", dbg_rdata, 32'h0);
        chk("rstacc_err", 32'(dbg_err), 32'h0);
        chk("rstacc_mem9", mem[9], 32'h0010_0073);
        rst     = 1'b0;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("rstacc_no_ack1", 32'(dbg_ack), 32'h0);
        @(negedge clk);
        chk("rstacc_no_ack2", 32'(dbg_ack), 32'h0);
        chk("rstacc_mem9_final", mem[9], 32'h0010_0073);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_debug_arbiter.md
# imem_debug_arbiter

Arbiter and sequencer for the word-addressed instruction memory. It shares the memory's single address/write port between the core fetch path and the external debug module. Debug reads and writes (program patching, breakpoint insertion, memory inspection) are serialised through a req/ack handshake. The core fetch is stalled only for the one cycle in which the debugger owns the memory.

## Interface
- `DEPTH`, 1000: number of 32-bit words in the instruction memory; valid word index 0..DEPTH-1.
- `AW`, 30: word-address width driven to memory (byte address [31:2]).
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `core_pc`  in  32: core fetch byte address.
- `core_instr`  out  32: instruction returned to the core (combinational from memory when the core owns the port).
- `core_stall`  out  1: core must hold `core_pc` and ignore `core_instr` this cycle.
- `dbg_req`  in  1: debug transaction request; held until `dbg_ack`.
- `dbg_we`  in  1: 1 = write, 0 = read; sampled with `dbg_req`.
- `dbg_addr`  in  32: debug byte address; sampled with `dbg_req`.
- `dbg_wdata`  in  32: write data; sampled with `dbg_req`.
- `dbg_ack`  out  1: one-cycle completion pulse.
- `dbg_rdata`  out  32: read data, valid while `dbg_ack`=1, held until the next ack.
- `dbg_err`  out  1: valid with `dbg_ack`; request was misaligned or out of range.
- `mem_addr`  out  AW: word address to memory.
- `mem_we`  out  1: memory write strobe; write commits on the rising edge that ends the cycle.
- `mem_wdata`  out  32: memory write data.
- `mem_rdata`  in  32: asynchronous memory read data for `mem_addr`.

## Operation
- FSM states: IDLE, ACCESS, ACK, RELEASE.
- IDLE: the core owns the port. `mem_addr`=`core_pc[31:2]`, `core_instr`=`mem_rdata`, `mem_we`=0. If `dbg_req`=1, capture `dbg_we`, `dbg_addr` and `dbg_wdata`, compute the error flag, and go to ACCESS.
- Error flag = (`dbg_addr[1:0]`≠0) OR (`dbg_addr[31:2]` ≥ DEPTH).
- ACCESS, no error: `core_stall`=1, `mem_addr`=captured address, `mem_we`=captured `dbg_we`, `mem_wdata`=captured data. On a read, `mem_rdata` is registered into `dbg_rdata`. Go to ACK.
- ACCESS, error: the memory is not touched. The core keeps the port, `core_stall`=0, `mem_we`=0, and `dbg_rdata` is loaded with 0. Go to ACK.
- On a successful write, `dbg_rdata` is loaded with the written data (read-back echo).
- ACK: `dbg_ack`=1 and `dbg_err`=captured error flag. The core owns the port. Go to RELEASE.
- RELEASE: the core owns the port. Stay in RELEASE while `dbg_req`=1; go to IDLE when `dbg_req`=0. This guarantees at least two core-owned cycles between debug accesses (no starvation).
- Core fetch out of range (`core_pc[31:2]` ≥ DEPTH): `core_instr`=32'h0000_0000. The memory is not indexed out of range; `mem_addr` is forced to 0.
- `dbg_req` deasserted while in ACCESS or ACK: the transaction still completes and `dbg_ack` still pulses.
- Reset values: state IDLE, `core_stall`=0, `dbg_ack`=0, `dbg_err`=0, `dbg_rdata`=0, `mem_we`=0, and all captured registers 0. `mem_we` is gated by `!rst`, so a write in ACCESS during a reset cycle does not commit.

## Timing
- `dbg_req` first seen high at edge t (state IDLE): ACCESS occupies cycle t..t+1, ACK occupies t+1..t+2.
- Request-to-ack latency is 2 cycles, fixed for reads, writes and errors.
- `core_stall` is high for exactly one cycle per non-error transaction and never for error transactions.
- Write data is visible to the core fetch in the ACK cycle.
- `dbg_ack` is a single-cycle pulse. The earliest next ACCESS is 2 cycles after ACK, since RELEASE must see `dbg_req`=0.
- All outputs except the core-owned `core_instr`/`mem_addr` paths are registered or decoded from state only.

## Test plan
- Reset, then `core_pc` = 0x08, 0x0C, 0x10 -> `core_instr` tracks memory words 2, 3, 4 combinationally, with `core_stall`=0 throughout.
- Debug write of 0x00100073 to 0x24 -> `mem_we` high for exactly one cycle at word 9, `core_stall` high for that same cycle, `dbg_ack` 2 cycles after the request with `dbg_err`=0 and `dbg_rdata`=0x00100073. A core fetch at 0x24 in the ACK cycle returns 0x00100073.
- Debug read of 0x28 with word 10 = 0x0034A503 -> ack after 2 cycles, `dbg_rdata`=0x0034A503, memory contents unchanged.
- Debug write to 0x26 (misaligned) and to 0xFA0 (word 1000 ≥ DEPTH) -> `dbg_ack` with `dbg_err`=1 and `dbg_rdata`=0, `mem_we` never asserted, `core_stall` never asserted.
- `dbg_req` held high for 6 cycles after ack -> no second transaction starts. The FSM stays in RELEASE until the request drops, and the core runs unstalled.
- `rst` asserted in the ACCESS cycle of a write to 0x24 -> the word is unchanged, all outputs reach reset values on the next edge, and no `dbg_ack` is produced.
